// File: rtl/fifo_multi_ch_pkg.sv
// fifo_multi_ch_pkg: shared types and helpers for the multi-channel FIFO.
//   clog2_min1  : ceil(log2(n)) but never less than 1 (index width helper)
//   ch_status_t : per-channel status {empty, full, aempty, afull, count}
//   CHW / AW    : channel-index and pointer widths for the default build
package fifo_multi_ch_pkg;

  // Index width that stays legal (>= 1 bit) even for a single entry.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DEPTH  = 16;
  localparam int CHW        = clog2_min1(DEF_NUM_CH);
  localparam int AW         = clog2_min1(DEF_DEPTH);

  // Wide enough for any channel depth up to 2**15 words; the top slices
  // off the AW+1 bits it actually publishes.
  localparam int CNT_MAX_W  = 16;

  typedef struct packed {
    logic                 empty;
    logic                 full;
    logic                 aempty;
    logic                 afull;
    logic [CNT_MAX_W-1:0] count;
  } ch_status_t;

endpackage

// File: rtl/fifo_ch_ctrl.sv
// fifo_ch_ctrl: pointer/count/flag bookkeeping for one FIFO channel.
// The top qualifies requests, so wr_en/rd_en are already "accepted".
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   wr_en, rd_en   : accepted write / read this cycle
//   wptr, rptr     : current write / read pointer within the partition
//   status         : registered flags and occupancy
module fifo_ch_ctrl
  import fifo_multi_ch_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [$clog2(DEPTH)-1:0] wptr,
  output logic [$clog2(DEPTH)-1:0] rptr,
  output ch_status_t               status
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   AFULL_C  = (PW+1)'(AFULL_TH);
  localparam logic [PW:0]   AEMPTY_C = (PW+1)'(AEMPTY_TH);

  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [PW:0]   cnt_r;
  logic [PW:0]   cnt_nxt_s;
  logic          empty_r;
  logic          full_r;
  logic          aempty_r;
  logic          afull_r;

  // Next occupancy; a paired write+read leaves it unchanged.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (wr_en && !rd_en) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else if (!wr_en && rd_en) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Pointers wrap naturally (power-of-2 depth); flags come from next count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      cnt_r    <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      aempty_r <= 1'b1;
      afull_r  <= 1'b0;
    end else begin
      wptr_r   <= wr_en ? (wptr_r + PTR_ONE) : wptr_r;
      rptr_r   <= rd_en ? (rptr_r + PTR_ONE) : rptr_r;
      cnt_r    <= cnt_nxt_s;
      empty_r  <= (cnt_nxt_s == '0);
      full_r   <= (cnt_nxt_s == CNT_FULL);
      aempty_r <= (cnt_nxt_s <= AEMPTY_C);
      afull_r  <= (cnt_nxt_s >= AFULL_C);
    end
  end

  assign wptr   = wptr_r;
  assign rptr   = rptr_r;
  assign status = {empty_r, full_r, aempty_r, afull_r, CNT_MAX_W'(cnt_r)};

endmodule

// File: rtl/fifo_multi_ch.sv
// fifo_multi_ch: NUM_CH independent FIFOs partitioned over one shared
// NUM_CH*DEPTH x WIDTH memory. Channel c owns words [c*DEPTH, c*DEPTH+DEPTH).
// Optional macro FIFO_MULTI_CH_BYPASS_EN: a same-cycle write+read on an
// empty channel forwards input_data to the output instead of storing it.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   write, wr_ch, input_data   : write request, channel, data
//   read, rd_ch                : read request, channel
//   output_data, output_valid  : registered read data, 1-cycle latency
//   empty/full/almost_*        : per-channel registered flags
//   count                      : packed per-channel occupancy (AW+1 each)
//   overflow, underflow        : sticky request-error flags
module fifo_multi_ch
  import fifo_multi_ch_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int NUM_CH    = 4,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   write,
  input  logic [clog2_min1(NUM_CH)-1:0]          wr_ch,
  input  logic [WIDTH-1:0]                       input_data,
  input  logic                                   read,
  input  logic [clog2_min1(NUM_CH)-1:0]          rd_ch,
  output logic [WIDTH-1:0]                       output_data,
  output logic                                   output_valid,
  output logic [NUM_CH-1:0]                      empty,
  output logic [NUM_CH-1:0]                      full,
  output logic [NUM_CH-1:0]                      almost_empty,
  output logic [NUM_CH-1:0]                      almost_full,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]    count,
  output logic                                   overflow,
  output logic                                   underflow
);

  localparam int CW = clog2_min1(NUM_CH);
  localparam int PW = $clog2(DEPTH);
  localparam int MW = clog2_min1(NUM_CH * DEPTH);

  logic [WIDTH-1:0]  mem_r [NUM_CH*DEPTH];
  logic [NUM_CH-1:0] wr_hit_s, rd_hit_s, wr_en_s, rd_en_s, byp_s;
  logic [NUM_CH-1:0] empty_s, full_s;
  logic [PW-1:0]     wptr_s [NUM_CH];
  logic [PW-1:0]     rptr_s [NUM_CH];
  ch_status_t        status_s [NUM_CH];
  logic [MW-1:0]     waddr_s, raddr_s;
  logic              ovf_set_s, unf_set_s;
  logic              cnt_unused_s;
  logic [WIDTH-1:0]  out_data_r;
  logic              out_valid_r, overflow_r, underflow_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fifo_ch_ctrl #(
      .DEPTH     (DEPTH),
      .AFULL_TH  (AFULL_TH),
      .AEMPTY_TH (AEMPTY_TH)
    ) u_ctrl (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_en_s[g]),
      .rd_en  (rd_en_s[g]),
      .wptr   (wptr_s[g]),
      .rptr   (rptr_s[g]),
      .status (status_s[g])
    );
    assign empty_s[g]      = status_s[g].empty;
    assign full_s[g]       = status_s[g].full;
    assign empty[g]        = status_s[g].empty;
    assign full[g]         = status_s[g].full;
    assign almost_empty[g] = status_s[g].aempty;
    assign almost_full[g]  = status_s[g].afull;
    assign count[g*(PW+1) +: PW+1] = status_s[g].count[PW:0];
  end

  // Channel decode and acceptance. An out-of-range index hits no channel,
  // so it is ignored and shows up only through the sticky error terms.
  always_comb begin
    wr_hit_s     = '0;
    rd_hit_s     = '0;
    wr_en_s      = '0;
    rd_en_s      = '0;
    byp_s        = '0;
    waddr_s      = '0;
    raddr_s      = '0;
    cnt_unused_s = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit_s[c] = write & (wr_ch == CW'(c));
      rd_hit_s[c] = read & (rd_ch == CW'(c));
`ifdef FIFO_MULTI_CH_BYPASS_EN
      byp_s[c]    = wr_hit_s[c] & rd_hit_s[c] & empty_s[c];
`else
      byp_s[c]    = 1'b0;
`endif
      rd_en_s[c]  = rd_hit_s[c] & ~empty_s[c];
      // A full channel still takes a write when the same cycle reads it.
      wr_en_s[c]  = wr_hit_s[c] & (~full_s[c] | rd_hit_s[c]) & ~byp_s[c];
      waddr_s     = wr_hit_s[c] ? MW'(c * DEPTH + int'(wptr_s[c])) : waddr_s;
      raddr_s     = rd_hit_s[c] ? MW'(c * DEPTH + int'(rptr_s[c])) : raddr_s;
      cnt_unused_s = cnt_unused_s ^ (^status_s[c].count);
    end
    ovf_set_s = (write & ~(|wr_hit_s)) | (|(wr_hit_s & full_s & ~rd_hit_s));
    unf_set_s = (read & ~(|rd_hit_s)) | (|(rd_hit_s & empty_s & ~byp_s));
  end

  // Shared storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (|wr_en_s) begin
      mem_r[waddr_s] <= input_data;
    end
  end

  // Output register: read data (or bypassed write data) one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (|rd_en_s) begin
      out_data_r  <= mem_r[raddr_s];
      out_valid_r <= 1'b1;
    end else if (|byp_s) begin
      out_data_r  <= input_data;
      out_valid_r <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r | ovf_set_s;
      underflow_r <= underflow_r | unf_set_s;
    end
  end

  assign output_data  = out_data_r;
  assign output_valid = out_valid_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_multi_ch.sv
module tb_fifo_multi_ch;

  localparam int WIDTH = 32;
  localparam int CNTW  = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              write = 1'b0;
  logic [1:0]        wr_ch = 2'd0;
  logic [WIDTH-1:0]  input_data = 32'd0;
  logic              read = 1'b0;
  logic [1:0]        rd_ch = 2'd0;
  logic [WIDTH-1:0]  output_data;
  logic              output_valid;
  logic [3:0]        empty, full, almost_empty, almost_full;
  logic [19:0]       count;
  logic              overflow, underflow;

  int checks = 0;
  int passes = 0;

  fifo_multi_ch dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .wr_ch        (wr_ch),
    .input_data   (input_data),
    .read         (read),
    .rd_ch        (rd_ch),
    .output_data  (output_data),
    .output_valid (output_valid),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] cnt_of(input int c);
    return count[c*CNTW +: CNTW];
  endfunction

  task automatic do_reset();
    write = 1'b0; read = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({empty, full, almost_empty, almost_full} !== {4'hF, 4'h0, 4'hF, 4'h0})
      $display("FAIL reset_flags got e=%h f=%h ae=%h af=%h want e=F f=0 ae=F af=0",
               empty, full, almost_empty, almost_full);
    else passes++;
    checks++;
    if ({overflow, underflow, output_valid, count} !== {1'b0, 1'b0, 1'b0, 20'd0})
      $display("FAIL reset_status got ov=%b un=%b ov_valid=%b count=%h want 0 0 0 0",
               overflow, underflow, output_valid, count);
    else passes++;
    checks++;
    if (output_data !== 32'd0)
      $display("FAIL reset_data got %h want 0", output_data);
    else passes++;
  endtask

  task automatic test_fill_ch0();
    for (int i = 0; i < 16; i++) begin
      write = 1'b1; wr_ch = 2'd0; input_data = 32'(2 * i);
      tick();
    end
    write = 1'b0;
    checks++;
    if ({full, empty, cnt_of(0)} !== {4'h1, 4'hE, 5'd16})
      $display("FAIL fill_ch0 got full=%h empty=%h cnt0=%0d want full=1 empty=E cnt0=16",
               full, empty, cnt_of(0));
    else passes++;
    write = 1'b1; wr_ch = 2'd0; input_data = 32'd99;
    tick();
    write = 1'b0;
    checks++;
    if ({overflow, cnt_of(0), full[0]} !== {1'b1, 5'd16, 1'b1})
      $display("FAIL overflow got ov=%b cnt0=%0d full0=%b want 1 16 1",
               overflow, cnt_of(0), full[0]);
    else passes++;
  endtask

  task automatic test_drain_ch0();
    for (int i = 0; i < 16; i++) begin
      read = 1'b1; rd_ch = 2'd0;
      tick();
      checks++;
      if ({output_valid, output_data} !== {1'b1, 32'(2 * i)})
        $display("FAIL drain_ch0[%0d] got v=%b d=%0d want v=1 d=%0d",
                 i, output_valid, output_data, 2 * i);
      else passes++;
    end
    read = 1'b0;
    tick();
    checks++;
    if ({empty[0], output_valid, underflow} !== {1'b1, 1'b0, 1'b0})
      $display("FAIL drained got empty0=%b v=%b un=%b want 1 0 0", empty[0], output_valid, underflow);
    else passes++;
    read = 1'b1; rd_ch = 2'd0;
    tick();
    read = 1'b0;
    checks++;
    if ({underflow, output_valid, output_data, overflow} !== {1'b1, 1'b0, 32'd30, 1'b1})
      $display("FAIL underflow got un=%b v=%b d=%0d ov=%b want 1 0 30 1",
               underflow, output_valid, output_data, overflow);
    else passes++;
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 8; i++) begin
      write = 1'b1; wr_ch = 2'd1; input_data = 32'(100 + i);
      tick();
      wr_ch = 2'd2; input_data = 32'(200 + i);
      tick();
    end
    write = 1'b0;
    checks++;
    if ({cnt_of(1), cnt_of(2), empty[0], empty[3]} !== {5'd8, 5'd8, 1'b1, 1'b1})
      $display("FAIL interleave_cnt got c1=%0d c2=%0d e0=%b e3=%b want 8 8 1 1",
               cnt_of(1), cnt_of(2), empty[0], empty[3]);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      read = 1'b1; rd_ch = 2'd1;
      tick();
      checks++;
      if ({output_valid, output_data} !== {1'b1, 32'(100 + i)})
        $display("FAIL interleave_ch1[%0d] got v=%b d=%0d want 1 %0d", i, output_valid, output_data, 100 + i);
      else passes++;
      rd_ch = 2'd2;
      tick();
      checks++;
      if ({output_valid, output_data} !== {1'b1, 32'(200 + i)})
        $display("FAIL interleave_ch2[%0d] got v=%b d=%0d want 1 %0d", i, output_valid, output_data, 200 + i);
      else passes++;
    end
    read = 1'b0;
    tick();
    checks++;
    if (empty !== 4'hF)
      $display("FAIL interleave_empty got %h want F", empty);
    else passes++;
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 16; i++) begin
      write = 1'b1; wr_ch = 2'd3; input_data = 32'(300 + i);
      tick();
    end
    write = 1'b1; wr_ch = 2'd3; input_data = 32'd999;
    read = 1'b1; rd_ch = 2'd3;
    tick();
    write = 1'b0; read = 1'b0;
    checks++;
    if ({output_valid, output_data, cnt_of(3), full[3]} !== {1'b1, 32'd300, 5'd16, 1'b1})
      $display("FAIL full_rw got v=%b d=%0d cnt3=%0d full3=%b want 1 300 16 1",
               output_valid, output_data, cnt_of(3), full[3]);
    else passes++;
    for (int i = 0; i < 16; i++) begin
      read = 1'b1; rd_ch = 2'd3;
      tick();
      checks++;
      if (output_data !== ((i == 15) ? 32'd999 : 32'(301 + i)))
        $display("FAIL full_wrap_drain[%0d] got %0d want %0d", i, output_data,
                 (i == 15) ? 999 : 301 + i);
      else passes++;
    end
    read = 1'b0;
  endtask

  task automatic test_thresholds();
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      write = 1'b1; wr_ch = 2'd0; input_data = 32'(n);
      tick();
      checks++;
      if ({almost_full[0], almost_empty[0]} !== {(n >= 14), (n <= 2)})
        $display("FAIL thresh_up[%0d] got af=%b ae=%b want af=%b ae=%b",
                 n, almost_full[0], almost_empty[0], (n >= 14), (n <= 2));
      else passes++;
    end
    write = 1'b0;
    for (int m = 15; m >= 0; m--) begin
      read = 1'b1; rd_ch = 2'd0;
      tick();
      checks++;
      if ({almost_full[0], almost_empty[0], cnt_of(0)} !== {(m >= 14), (m <= 2), 5'(m)})
        $display("FAIL thresh_down[%0d] got af=%b ae=%b cnt=%0d want af=%b ae=%b",
                 m, almost_full[0], almost_empty[0], cnt_of(0), (m >= 14), (m <= 2));
      else passes++;
    end
    read = 1'b0;
    write = 1'b1; wr_ch = 2'd0; input_data = 32'd500;
    tick();
    for (int k = 1; k <= 40; k++) begin
      write = 1'b1; wr_ch = 2'd0; input_data = 32'(500 + k);
      read = 1'b1; rd_ch = 2'd0;
      tick();
      checks++;
      if ({output_valid, output_data, cnt_of(0)} !== {1'b1, 32'(499 + k), 5'd1})
        $display("FAIL wrap_pair[%0d] got v=%b d=%0d cnt=%0d want 1 %0d 1",
                 k, output_valid, output_data, cnt_of(0), 499 + k);
      else passes++;
    end
    write = 1'b0; read = 1'b0;
    checks++;
    if ({overflow, underflow} !== 2'b00)
      $display("FAIL wrap_errors got ov=%b un=%b want 0 0", overflow, underflow);
    else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      write = 1'b1; wr_ch = 2'd0; input_data = 32'(10 + i);
      tick();
    end
    write = 1'b0;
    read = 1'b1; rd_ch = 2'd0;
    tick();
    checks++;
    if ({output_valid, output_data} !== {1'b1, 32'd10})
      $display("FAIL pre_reset_read got v=%b d=%0d want 1 10", output_valid, output_data);
    else passes++;
    reset = 1'b1;
    tick();
    reset = 1'b0; read = 1'b0;
    checks++;
    if ({output_valid, empty, full, almost_empty, almost_full, count} !==
        {1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 20'd0})
      $display("FAIL reset_mid got v=%b e=%h f=%h ae=%h af=%h cnt=%h want 0 F 0 F 0 0",
               output_valid, empty, full, almost_empty, almost_full, count);
    else passes++;
  endtask

  task automatic test_same_ch_empty();
    write = 1'b1; wr_ch = 2'd0; input_data = 32'h0000_00AB;
    read = 1'b1; rd_ch = 2'd0;
    tick();
    write = 1'b0; read = 1'b0;
`ifdef FIFO_MULTI_CH_BYPASS_EN
    checks++;
    if ({output_valid, output_data, underflow, cnt_of(0)} !== {1'b1, 32'h0000_00AB, 1'b0, 5'd0})
      $display("FAIL bypass got v=%b d=%h un=%b cnt=%0d want 1 AB 0 0",
               output_valid, output_data, underflow, cnt_of(0));
    else passes++;
`else
    checks++;
    if ({output_valid, underflow, cnt_of(0)} !== {1'b0, 1'b1, 5'd1})
      $display("FAIL no_bypass got v=%b un=%b cnt=%0d want 0 1 1",
               output_valid, underflow, cnt_of(0));
    else passes++;
    read = 1'b1; rd_ch = 2'd0;
    tick();
    read = 1'b0;
    checks++;
    if ({output_valid, output_data, empty[0]} !== {1'b1, 32'h0000_00AB, 1'b1})
      $display("FAIL no_bypass_read got v=%b d=%h e0=%b want 1 AB 1",
               output_valid, output_data, empty[0]);
    else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_fill_ch0();
    test_drain_ch0();
    test_interleave();
    test_full_wrap();
    test_thresholds();
    test_reset_mid();
    test_same_ch_empty();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
